dmem_arbiter: RTL and testbench

// - Two-requester arbiter/sequencer for the single-port synchronous-read data memory (16-bit words, 256 deep).
// - Port 0 = pipeline MEM stage; port 1 = secondary master (debug loader / DMA).
// - Grants at most one access per cycle and drives the memory address, write data and write enable.
// - Returns read data to the granted port one cycle later with a valid strobe; filters out-of-range addresses.

---
 rtl/dmem_arbiter_if.sv | 19 +
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for the data memory arbiter: one instance per requester.
// The requester holds req/we/addr/wd until gnt; read data returns on rvalid/rdata.
interface dmem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wd;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, output we, output addr, output wd,
                  input  gnt, input  rvalid, input  rdata);
  modport slave  (input  req, input  we, input  addr, input  wd,
                  output gnt, output rvalid, output rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port synchronous-read data memory.
// Port p0 is the pipeline MEM stage, port p1 the secondary master (loader/DMA).
// One access per cycle; read data returns to the issuing port one cycle after gnt.
// Out-of-range accesses (addr >= DEPTH) are filtered: writes dropped, reads return 0,
// and err_oob pulses the following cycle.
// Optional build macro DMEM_ARB_PERF_EN adds saturating grant/conflict counters.
module dmem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int DEPTH    = 256,
  parameter int FIXED_P0 = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave p0,
  dmem_arbiter_if.slave p1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          err_oob
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_gnt0,
  output logic [15:0]   perf_gnt1,
  output logic [15:0]   perf_conflict
`endif
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] MAX_WAIT_C = WCW'(MAX_WAIT);
  localparam logic [AW:0]    DEPTH_C    = (AW + 1)'(DEPTH);

  function automatic logic [WCW-1:0] wait_inc(input logic [WCW-1:0] v);
    return (v == MAX_WAIT_C) ? v : v + 1'b1;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

`ifdef DMEM_ARB_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic           rr_ptr;
  logic [WCW-1:0] wait_cnt;
  logic [AW-1:0]  addr_hold;
  logic           sel1;
  logic           gnt0;
  logic           gnt1;
  logic           any_gnt;
  logic           acc_we;
  logic           acc_oob;
  logic [AW-1:0]  acc_addr;
  logic [DW-1:0]  acc_wd;

  logic [1:0]     rsp_vld_p1;
  logic           rsp_oob_p1;
  logic [DW-1:0]  rsp_data_p1;
  logic [DW-1:0]  rdata_hold0;
  logic [DW-1:0]  rdata_hold1;

  // Arbitration and selection of the winning request (combinational grant)
  always_comb begin
    sel1 = 1'b0;
    if (p1.req) begin
      if (!p0.req)             sel1 = 1'b1;
      else if (FIXED_P0 != 0)  sel1 = (wait_cnt == MAX_WAIT_C);
      else                     sel1 = rr_ptr;
    end
    gnt1     = rst_n & sel1;
    gnt0     = rst_n & p0.req & ~sel1;
    any_gnt  = gnt0 | gnt1;
    acc_addr = gnt1 ? p1.addr : p0.addr;
    acc_wd   = gnt1 ? p1.wd   : p0.wd;
    acc_we   = gnt1 ? p1.we   : p0.we;
    acc_oob  = ~in_range(acc_addr);
  end

  assign p0.gnt   = gnt0;
  assign p1.gnt   = gnt1;
  assign mem_addr = any_gnt ? acc_addr : addr_hold;
  assign mem_wd   = any_gnt ? acc_wd : '0;
  assign mem_we   = any_gnt & acc_we & ~acc_oob;

  // Arbitration history: round-robin pointer, p1 starvation counter, last granted address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      wait_cnt  <= '0;
      addr_hold <= '0;
    end else begin
      if (gnt0)      rr_ptr <= 1'b1;
      else if (gnt1) rr_ptr <= 1'b0;
      if (!p1.req || gnt1) wait_cnt <= '0;
      else                 wait_cnt <= wait_inc(wait_cnt);
      if (any_gnt) addr_hold <= acc_addr;
    end
  end

  // Response stage p1: remember which port issued a read and whether it was out of range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p1 <= 2'b00;
      rsp_oob_p1 <= 1'b0;
      err_oob    <= 1'b0;
    end else begin
      rsp_vld_p1 <= {gnt1 & ~acc_we, gnt0 & ~acc_we};
      rsp_oob_p1 <= acc_oob;
      err_oob    <= any_gnt & acc_oob;
    end
  end

  // Memory data arrives during the response cycle itself, so it is forwarded
  // directly while rvalid is high and captured for the hold value afterwards.
  assign rsp_data_p1 = rsp_oob_p1 ? '0 : mem_rd;
  assign p0.rvalid   = rsp_vld_p1[0];
  assign p1.rvalid   = rsp_vld_p1[1];
  assign p0.rdata    = rsp_vld_p1[0] ? rsp_data_p1 : rdata_hold0;
  assign p1.rdata    = rsp_vld_p1[1] ? rsp_data_p1 : rdata_hold1;

  // Per-port read data hold: keeps the last delivered word until the next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_hold0 <= '0;
      rdata_hold1 <= '0;
    end else begin
      if (rsp_vld_p1[0]) rdata_hold0 <= rsp_data_p1;
      if (rsp_vld_p1[1]) rdata_hold1 <= rsp_data_p1;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Saturating performance counters: grants per port and cycles with both requesting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_gnt0     <= '0;
      perf_gnt1     <= '0;
      perf_conflict <= '0;
    end else begin
      if (gnt0)              perf_gnt0     <= sat_inc16(perf_gnt0);
      if (gnt1)              perf_gnt1     <= sat_inc16(perf_gnt1);
      if (p0.req && p1.req)  perf_conflict <= sat_inc16(perf_conflict);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (fixed priority and round-robin), each with
// its own behavioural memory, driven by randomized and directed requests.
// A reference model predicts grants and memory writes; expected read responses are
// queued per port and popped by an independent monitor when rvalid appears.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int DEPTH    = 256;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // stimulus [dut][port]
  logic        req  [2][2];
  logic        we   [2][2];
  logic [15:0] addr [2][2];
  logic [15:0] wd   [2][2];
  // observed outputs
  logic        gnt    [2][2];
  logic        rvalid [2][2];
  logic [15:0] rdata  [2][2];
  logic [15:0] mem_addr_w [2];
  logic [15:0] mem_wd_w   [2];
  logic        mem_we_w   [2];
  logic [15:0] mem_rd_w   [2];
  logic        err_w      [2];
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] pg0 [2];
  logic [15:0] pg1 [2];
  logic [15:0] pcf [2];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(int d, int i);
    return 16'((i * 40503) ^ (d * 911) ^ 16'h5A5A);
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    dmem_arbiter_if #(.AW(AW), .DW(DW)) pif0 ();
    dmem_arbiter_if #(.AW(AW), .DW(DW)) pif1 ();
    logic [15:0] mem_dev [DEPTH];
    logic [15:0] rd_q;
    bit          mem_init;

    assign pif0.req  = req[d][0];
    assign pif0.we   = we[d][0];
    assign pif0.addr = addr[d][0];
    assign pif0.wd   = wd[d][0];
    assign pif1.req  = req[d][1];
    assign pif1.we   = we[d][1];
    assign pif1.addr = addr[d][1];
    assign pif1.wd   = wd[d][1];
    assign gnt[d][0]    = pif0.gnt;
    assign gnt[d][1]    = pif1.gnt;
    assign rvalid[d][0] = pif0.rvalid;
    assign rvalid[d][1] = pif1.rvalid;
    assign rdata[d][0]  = pif0.rdata;
    assign rdata[d][1]  = pif1.rdata;
    assign mem_rd_w[d]  = rd_q;

    dmem_arbiter #(
      .AW(AW), .DW(DW), .DEPTH(DEPTH), .FIXED_P0((d == 0) ? 1 : 0), .MAX_WAIT(MAX_WAIT)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .p0(pif0),
      .p1(pif1),
      .mem_addr(mem_addr_w[d]),
      .mem_wd(mem_wd_w[d]),
      .mem_we(mem_we_w[d]),
      .mem_rd(rd_q),
      .err_oob(err_w[d])
`ifdef DMEM_ARB_PERF_EN
      ,
      .perf_gnt0(pg0[d]),
      .perf_gnt1(pg1[d]),
      .perf_conflict(pcf[d])
`endif
    );

    // synchronous-read single-port memory (256 words, low address bits only)
    always @(posedge clk) begin
      if (!mem_init) begin
        for (int i = 0; i < DEPTH; i++) mem_dev[i] <= init_word(d, i);
        mem_init <= 1'b1;
      end else if (mem_we_w[d]) begin
        mem_dev[mem_addr_w[d][7:0]] <= mem_wd_w[d];
      end
      rd_q <= mem_dev[mem_addr_w[d][7:0]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int stamp; logic [15:0] data; } rsp_t;
  rsp_t        exp_q [4][$];
  logic [15:0] ref_mem [2][DEPTH];
  int          p1_wait [2];
  int          rr_last [2];
  logic [15:0] hold_addr [2];
  bit          err_due [2];
  bit          g_seen [2][2];
  int          pc [2][3];

  initial begin : model
    int win;
    bit oob;
    logic [15:0] a;
    rsp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          chk("rst_gnt0", gnt[d][0], 0);
          chk("rst_gnt1", gnt[d][1], 0);
          chk("rst_mem_we", mem_we_w[d], 0);
          chk("rst_mem_addr", mem_addr_w[d], 0);
          chk("rst_mem_wd", mem_wd_w[d], 0);
          chk("rst_err_oob", err_w[d], 0);
`ifdef DMEM_ARB_PERF_EN
          chk("rst_perf_gnt0", pg0[d], 0);
          chk("rst_perf_gnt1", pg1[d], 0);
          chk("rst_perf_conflict", pcf[d], 0);
`endif
          p1_wait[d] = 0; rr_last[d] = 1; hold_addr[d] = '0; err_due[d] = 1'b0;
          g_seen[d][0] = 1'b0; g_seen[d][1] = 1'b0;
          for (int j = 0; j < 3; j++) pc[d][j] = 0;
        end else begin
          chk("err_oob", err_w[d], err_due[d]);
`ifdef DMEM_ARB_PERF_EN
          chk("perf_gnt0", pg0[d], pc[d][0]);
          chk("perf_gnt1", pg1[d], pc[d][1]);
          chk("perf_conflict", pcf[d], pc[d][2]);
`endif
          win = -1;
          if (req[d][0] && req[d][1]) begin
            if (d == 0) win = (p1_wait[d] == MAX_WAIT) ? 1 : 0;
            else        win = (rr_last[d] == 0) ? 1 : 0;
          end else if (req[d][0]) win = 0;
          else if (req[d][1])     win = 1;
          chk("gnt0", gnt[d][0], win == 0);
          chk("gnt1", gnt[d][1], win == 1);
          g_seen[d][0] = (win == 0);
          g_seen[d][1] = (win == 1);
          err_due[d] = 1'b0;
          if (win >= 0) begin
            a = addr[d][win];
            oob = (a >= DEPTH);
            chk("mem_addr", mem_addr_w[d], a);
            chk("mem_wd", mem_wd_w[d], wd[d][win]);
            chk("mem_we", mem_we_w[d], we[d][win] && !oob);
            hold_addr[d] = a;
            err_due[d] = oob;
            if (!we[d][win]) begin
              e.stamp = cyc;
              e.data  = oob ? 16'h0000 : ref_mem[d][a[7:0]];
              exp_q[d*2+win].push_back(e);
            end else if (!oob) begin
              ref_mem[d][a[7:0]] = wd[d][win];
            end
          end else begin
            chk("mem_addr_hold", mem_addr_w[d], hold_addr[d]);
            chk("mem_we_idle", mem_we_w[d], 0);
          end
          if (req[d][1] && win != 1) p1_wait[d] = (p1_wait[d] < MAX_WAIT) ? p1_wait[d] + 1 : MAX_WAIT;
          else                       p1_wait[d] = 0;
          if (win >= 0) rr_last[d] = win;
          if (win == 0 && pc[d][0] < 65535) pc[d][0]++;
          if (win == 1 && pc[d][1] < 65535) pc[d][1]++;
          if (req[d][0] && req[d][1] && pc[d][2] < 65535) pc[d][2]++;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  logic [15:0] last_rd [4];

  initial begin : monitor
    int d;
    int k;
    rsp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        d = i / 2;
        k = i % 2;
        if (!rst_n) begin
          chk("rst_rvalid", rvalid[d][k], 0);
          chk("rst_rdata", rdata[d][k], 0);
          exp_q[i].delete();
          last_rd[i] = '0;
        end else if (rvalid[d][k]) begin
          checks++;
          if (exp_q[i].size() == 0 || exp_q[i][0].stamp != cyc - 1) begin
            errors++;
            $display("FAIL unexpected_rvalid dut%0d port%0d: got rvalid=1 expected 0 at t=%0t", d, k, $time);
          end else begin
            e = exp_q[i].pop_front();
            chk("rdata", rdata[d][k], e.data);
            last_rd[i] = e.data;
          end
        end else begin
          chk("rdata_hold", rdata[d][k], last_rd[i]);
          if (exp_q[i].size() != 0 && exp_q[i][0].stamp < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_rvalid dut%0d port%0d: got rvalid=0 expected 1 at t=%0t", d, k, $time);
            void'(exp_q[i].pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic new_req(input int d, input int k);
    req[d][k] = 1'b1;
    we[d][k]  = ($urandom_range(0, 2) == 0);
    wd[d][k]  = 16'($urandom);
    if ($urandom_range(0, 15) == 0) begin
      case ($urandom_range(0, 2))
        0:       addr[d][k] = 16'h0100;
        1:       addr[d][k] = 16'hFFFF;
        default: addr[d][k] = 16'(256 + $urandom_range(0, 65279));
      endcase
    end else if ($urandom_range(0, 3) == 0) begin
      addr[d][k] = 16'($urandom_range(0, 255));
    end else begin
      addr[d][k] = 16'($urandom_range(0, 15));
    end
  endtask

  // sets next-cycle inputs; held requests stay stable until granted
  task automatic drive(input int pct, input bit drops);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        if (req[d][k] && !g_seen[d][k]) begin
          if (drops && $urandom_range(0, 15) == 0) req[d][k] = 1'b0;
        end else if ($urandom_range(0, 99) < pct) begin
          new_req(d, k);
        end else begin
          req[d][k] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int d = 0; d < 2; d++) begin
      req[d][0] = 1'b0;
      req[d][1] = 1'b0;
    end
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // same request on port k of both instances; returns one cycle after the grant
  task automatic issue(input int k, input bit w, input logic [15:0] a, input logic [15:0] v);
    bit done;
    for (int d = 0; d < 2; d++) begin
      req[d][k] = 1'b1; we[d][k] = w; addr[d][k] = a; wd[d][k] = v;
    end
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) if (req[d][k] && g_seen[d][k]) req[d][k] = 1'b0;
      done = !req[0][k] && !req[1][k];
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL grant_timeout port%0d: got no grant expected grant within 20 cycles", k);
      for (int d = 0; d < 2; d++) req[d][k] = 1'b0;
    end
  endtask

  initial begin : stim
    int cnt1 [2];
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = init_word(d, i);
      for (int k = 0; k < 2; k++) begin
        req[d][k] = 1'b1; we[d][k] = 1'b0; addr[d][k] = 16'h0020; wd[d][k] = 16'h0;
      end
    end
    // reset held with both requesting
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("gnt_at_release", gnt[d][0], 1);
    @(posedge clk); #1;
    repeat (6) begin
      drive(0, 1'b0);
      @(posedge clk); #1;
    end
    idle(2);

    // write then read back through p0
    issue(0, 1'b1, 16'h0010, 16'hBEEF);
    issue(0, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("p0_rvalid_beef", rvalid[d][0], 1);
      chk("p0_rdata_beef", rdata[d][0], 16'hBEEF);
    end
    @(posedge clk); #1;

    // out-of-range write and read on p1, then word 0 must be untouched
    issue(1, 1'b1, 16'h0100, 16'h1234);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("oob_wr_err", err_w[d], 1);
    @(posedge clk); #1;
    issue(1, 1'b0, 16'h0100, 16'h0000);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("oob_rd_rvalid", rvalid[d][1], 1);
      chk("oob_rd_rdata", rdata[d][1], 0);
      chk("oob_rd_err", err_w[d], 1);
    end
    @(posedge clk); #1;
    issue(1, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("word0_intact", rdata[d][1], init_word(d, 0));
    @(posedge clk); #1;
    idle(3);

    // both ports held continuously for 20 cycles
    cnt1[0] = 0; cnt1[1] = 0;
    for (int n = 0; n < 20; n++) begin
      drive(100, 1'b0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (gnt[d][1]) cnt1[d]++;
      @(posedge clk); #1;
    end
    chk("fixed_p1_share", cnt1[0], 4);
    chk("rr_p1_share", cnt1[1], 10);
    idle(3);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      drive(50, 1'b1);
      @(posedge clk); #1;
    end
    for (int n = 0; n < 10; n++) begin
      drive(0, 1'b0);
      @(posedge clk); #1;
    end
    idle(3);

    // reset in the cycle after a read grant: the response must be lost
    issue(0, 1'b0, 16'h0005, 16'h0000);
    rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("rvalid_lost", rvalid[d][0], 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
